// File: rtl/ddr_cmd_arb_if.sv
// Request/grant bundle between DDR command requesters and the ddr_cmd_arb arbiter.
// master = requester side, slave = arbiter side.
interface ddr_cmd_arb_if;
    logic       act_req;
    logic       pre_req;
    logic       ref_req;
    logic       cas_req;
    logic       cas_rw;
    logic       act_gnt;
    logic       cas_gnt;
    logic       pre_gnt;
    logic       ref_gnt;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic       busy;

    modport master (
        output act_req, pre_req, ref_req, cas_req, cas_rw,
        input  act_gnt, cas_gnt, pre_gnt, ref_gnt, cmd_valid, cmd_code, busy
    );

    modport slave (
        input  act_req, pre_req, ref_req, cas_req, cas_rw,
        output act_gnt, cas_gnt, pre_gnt, ref_gnt, cmd_valid, cmd_code, busy
    );
endinterface

// File: rtl/ddr_cmd_arb.sv
// Fixed-priority DDR command arbiter (REF > PRE > CAS > ACT) enforcing tRRD, tCCD and tRFC spacing.
// Define DDR_CMD_ARB_REFRESH_EN to build the refresh path (REF grant, ARB_REF_WAIT, rfc_cnt).
module ddr_cmd_arb #(
    parameter int TRRD = 4,
    parameter int TCCD = 4,
    parameter int TRFC = 20
) (
    input  logic         clock_t,
    input  logic         reset,
    ddr_cmd_arb_if.slave bus
);
    localparam int T_MAX_RC = (TRRD > TCCD) ? TRRD : TCCD;
    localparam int T_MAX    = (T_MAX_RC > TRFC) ? T_MAX_RC : TRFC;
    localparam int CW       = $clog2(T_MAX) + 1;

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] RRD_LOAD = CW'(TRRD - 1);
    localparam logic [CW-1:0] CCD_LOAD = CW'(TCCD - 1);

    localparam logic [2:0] CMD_NOP = 3'b000;
    localparam logic [2:0] CMD_ACT = 3'b001;
    localparam logic [2:0] CMD_RD  = 3'b010;
    localparam logic [2:0] CMD_WR  = 3'b011;
    localparam logic [2:0] CMD_PRE = 3'b100;
    localparam logic [2:0] CMD_REF = 3'b101;

    typedef enum logic [0:0] {
        ARB_RUN      = 1'b0,
        ARB_REF_WAIT = 1'b1
    } arb_state_e;

    arb_state_e    r_state;
    logic [CW-1:0] r_rrd_cnt;
    logic [CW-1:0] r_ccd_cnt;
    logic          r_act_gnt;
    logic          r_cas_gnt;
    logic          r_pre_gnt;
    logic          r_ref_gnt;
    logic          r_cmd_valid;
    logic [2:0]    r_cmd_code;
    logic          r_busy;

    logic          w_run;
    logic          w_act_ok;
    logic          w_cas_ok;
    logic          w_pre_ok;
    logic          w_ref_ok;
    logic          w_gnt_act;
    logic          w_gnt_cas;
    logic          w_gnt_pre;
    logic          w_gnt_ref;
    logic          w_ref_busy_nxt;
    logic [CW-1:0] w_rrd_nxt;
    logic [CW-1:0] w_ccd_nxt;
    logic [2:0]    w_code_nxt;

    assign w_run = (r_state == ARB_RUN);

    // A request is still high during its own grant cycle; masking it with the grant prevents a double issue.
    assign w_act_ok = bus.act_req & ~r_act_gnt & (r_rrd_cnt == CNT_ZERO);
    assign w_cas_ok = bus.cas_req & ~r_cas_gnt & (r_ccd_cnt == CNT_ZERO);
    assign w_pre_ok = bus.pre_req & ~r_pre_gnt;

`ifdef DDR_CMD_ARB_REFRESH_EN
    localparam logic [CW-1:0] RFC_LOAD = CW'(TRFC - 1);

    logic [CW-1:0] r_rfc_cnt;

    assign w_ref_ok       = bus.ref_req & ~r_ref_gnt;
    assign w_ref_busy_nxt = w_gnt_ref | ((r_state == ARB_REF_WAIT) & (r_rfc_cnt != CNT_ZERO));
`else
    assign w_ref_ok       = 1'b0;
    assign w_ref_busy_nxt = 1'b0;
`endif

    // Ineligible higher-priority requests drop out here, so they never block a lower eligible one.
    assign w_gnt_ref = w_run & w_ref_ok;
    assign w_gnt_pre = w_run & w_pre_ok & ~w_ref_ok;
    assign w_gnt_cas = w_run & w_cas_ok & ~w_ref_ok & ~w_pre_ok;
    assign w_gnt_act = w_run & w_act_ok & ~w_ref_ok & ~w_pre_ok & ~w_cas_ok;

    // Command code for whichever request wins this cycle.
    always_comb begin
        w_code_nxt = CMD_NOP;
        if (w_gnt_ref) begin
            w_code_nxt = CMD_REF;
        end else if (w_gnt_pre) begin
            w_code_nxt = CMD_PRE;
        end else if (w_gnt_cas) begin
            w_code_nxt = bus.cas_rw ? CMD_WR : CMD_RD;
        end else if (w_gnt_act) begin
            w_code_nxt = CMD_ACT;
        end else begin
            w_code_nxt = CMD_NOP;
        end
    end

    // Next ACT-to-ACT spacing count: reload on grant, otherwise count down and hold at zero.
    always_comb begin
        w_rrd_nxt = CNT_ZERO;
        if (w_gnt_act) begin
            w_rrd_nxt = RRD_LOAD;
        end else if (r_rrd_cnt != CNT_ZERO) begin
            w_rrd_nxt = r_rrd_cnt - CNT_ONE;
        end else begin
            w_rrd_nxt = CNT_ZERO;
        end
    end

    // Next CAS-to-CAS spacing count: reload on grant, otherwise count down and hold at zero.
    always_comb begin
        w_ccd_nxt = CNT_ZERO;
        if (w_gnt_cas) begin
            w_ccd_nxt = CCD_LOAD;
        end else if (r_ccd_cnt != CNT_ZERO) begin
            w_ccd_nxt = r_ccd_cnt - CNT_ONE;
        end else begin
            w_ccd_nxt = CNT_ZERO;
        end
    end

    // Arbiter state, spacing timers and all registered outputs.
    always_ff @(posedge clock_t) begin
        if (reset) begin
            r_state     <= ARB_RUN;
            r_rrd_cnt   <= CNT_ZERO;
            r_ccd_cnt   <= CNT_ZERO;
            r_act_gnt   <= 1'b0;
            r_cas_gnt   <= 1'b0;
            r_pre_gnt   <= 1'b0;
            r_ref_gnt   <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_cmd_code  <= CMD_NOP;
            r_busy      <= 1'b0;
`ifdef DDR_CMD_ARB_REFRESH_EN
            r_rfc_cnt   <= CNT_ZERO;
`endif
        end else begin
            r_act_gnt   <= w_gnt_act;
            r_cas_gnt   <= w_gnt_cas;
            r_pre_gnt   <= w_gnt_pre;
            r_ref_gnt   <= w_gnt_ref;
            r_cmd_valid <= w_gnt_act | w_gnt_cas | w_gnt_pre | w_gnt_ref;
            r_cmd_code  <= w_code_nxt;
            r_rrd_cnt   <= w_rrd_nxt;
            r_ccd_cnt   <= w_ccd_nxt;
            r_busy      <= w_ref_busy_nxt | (w_rrd_nxt != CNT_ZERO) | (w_ccd_nxt != CNT_ZERO);
`ifdef DDR_CMD_ARB_REFRESH_EN
            case (r_state)
                ARB_RUN: begin
                    if (w_gnt_ref) begin
                        r_state   <= ARB_REF_WAIT;
                        r_rfc_cnt <= RFC_LOAD;
                    end else begin
                        r_state   <= ARB_RUN;
                        r_rfc_cnt <= CNT_ZERO;
                    end
                end
                ARB_REF_WAIT: begin
                    // The cycle that sees rfc_cnt at zero only returns to ARB_RUN; grants resume the next cycle.
                    if (r_rfc_cnt == CNT_ZERO) begin
                        r_state   <= ARB_RUN;
                        r_rfc_cnt <= CNT_ZERO;
                    end else begin
                        r_state   <= ARB_REF_WAIT;
                        r_rfc_cnt <= r_rfc_cnt - CNT_ONE;
                    end
                end
                default: begin
                    r_state   <= ARB_RUN;
                    r_rfc_cnt <= CNT_ZERO;
                end
            endcase
`else
            r_state <= ARB_RUN;
`endif
        end
    end

    assign bus.act_gnt   = r_act_gnt;
    assign bus.cas_gnt   = r_cas_gnt;
    assign bus.pre_gnt   = r_pre_gnt;
    assign bus.ref_gnt   = r_ref_gnt;
    assign bus.cmd_valid = r_cmd_valid;
    assign bus.cmd_code  = r_cmd_code;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_ddr_cmd_arb.sv
// Self-checking bench for ddr_cmd_arb: directed scenarios plus a randomized run against a timing-rule model.
// Refresh scenarios are selected by DDR_CMD_ARB_REFRESH_EN, matching the design build.
module tb_ddr_cmd_arb;
    localparam int TRRD = 4;
    localparam int TCCD = 4;
    localparam int TRFC = 20;
`ifdef DDR_CMD_ARB_REFRESH_EN
    localparam bit REF_EN = 1'b1;
`else
    localparam bit REF_EN = 1'b0;
`endif

    logic clock_t = 1'b0;
    logic reset   = 1'b1;
    int   checks  = 0;
    int   errors  = 0;

    ddr_cmd_arb_if bus();

    ddr_cmd_arb #(.TRRD(TRRD), .TCCD(TCCD), .TRFC(TRFC)) dut (
        .clock_t (clock_t),
        .reset   (reset),
        .bus     (bus.slave)
    );

    always #5 clock_t = ~clock_t;

    // Observed outputs packed as {act,cas,pre,ref,valid,code[2:0],busy}.
    function automatic logic [8:0] obs();
        return {bus.act_gnt, bus.cas_gnt, bus.pre_gnt, bus.ref_gnt,
                bus.cmd_valid, bus.cmd_code, bus.busy};
    endfunction

    // Grant ids: 0 none, 1 ACT, 2 CAS, 3 PRE, 4 REF.
    function automatic logic [2:0] code_of(input int g, input logic rw);
        case (g)
            1:       return 3'b001;
            2:       return rw ? 3'b011 : 3'b010;
            3:       return 3'b100;
            4:       return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [8:0] pack(input int g, input logic [2:0] code, input logic bsy);
        return {(g == 1), (g == 2), (g == 3), (g == 4), (g != 0), code, bsy};
    endfunction

    task automatic tick();
        @(posedge clock_t);
        #1;
    endtask

    task automatic set_reqs(input logic a, input logic c, input logic rw, input logic p, input logic r);
        bus.act_req = a;
        bus.cas_req = c;
        bus.cas_rw  = rw;
        bus.pre_req = p;
        bus.ref_req = r;
    endtask

    task automatic idle(input int n);
        set_reqs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        set_reqs(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs() !== 9'b0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got=%b expected=%b", i, obs(), 9'b0);
            end
        end
        set_reqs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        checks++;
        if (obs() !== 9'b0) begin
            errors++;
            $display("FAIL reset_release: got=%b expected=%b", obs(), 9'b0);
        end
    endtask

    task automatic test_act_spacing();
        logic [8:0] exp;
        int g;
        idle(6);
        set_reqs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) begin
            tick();
            g   = ((k % TRRD) == 0) ? 1 : 0;
            exp = pack(g, code_of(g, 1'b0), (k % TRRD) != (TRRD - 1));
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL act_spacing k=%0d: got=%b expected=%b", k, obs(), exp);
            end
        end
        idle(6);
    endtask

    task automatic test_cas_priority();
        logic [8:0] exp [3];
        exp[0] = pack(2, 3'b011, 1'b1);
        exp[1] = pack(1, 3'b001, 1'b1);
        exp[2] = pack(0, 3'b000, 1'b1);
        set_reqs(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (obs() !== exp[k]) begin
                errors++;
                $display("FAIL cas_priority k=%0d: got=%b expected=%b", k, obs(), exp[k]);
            end
            if (k == 1) bus.cas_req = 1'b0;
        end
        idle(6);
    endtask

    task automatic test_ccd_bypass();
        logic [8:0] exp [6];
        exp[0] = pack(2, 3'b010, 1'b1);
        exp[1] = pack(1, 3'b001, 1'b1);
        exp[2] = pack(0, 3'b000, 1'b1);
        exp[3] = pack(0, 3'b000, 1'b1);
        exp[4] = pack(2, 3'b011, 1'b1);
        exp[5] = pack(0, 3'b000, 1'b1);
        set_reqs(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (obs() !== exp[k]) begin
                errors++;
                $display("FAIL ccd_bypass k=%0d: got=%b expected=%b", k, obs(), exp[k]);
            end
            if (k == 0) begin
                bus.act_req = 1'b1;
                bus.cas_rw  = 1'b1;
            end
            if (k == 2) bus.act_req = 1'b0;
        end
        idle(6);
    endtask

`ifdef DDR_CMD_ARB_REFRESH_EN
    task automatic test_refresh();
        logic [8:0] exp;
        int g;
        set_reqs(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k <= TRFC + 2; k++) begin
            tick();
            g   = (k == 0) ? 4 : ((k == TRFC + 1) ? 3 : 0);
            exp = pack(g, code_of(g, 1'b0), k < TRFC);
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL refresh k=%0d: got=%b expected=%b", k, obs(), exp);
            end
            if (k == 1) bus.ref_req = 1'b0;
        end
        idle(6);
    endtask

    task automatic test_reset_mid_refresh();
        logic [8:0] exp;
        int g;
        set_reqs(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 9; k++) begin
            tick();
            if (k == 5 || k == 6) begin
                exp = 9'b0;
            end else begin
                g   = (k == 0) ? 4 : ((k == 7) ? 1 : 0);
                exp = pack(g, code_of(g, 1'b0), 1'b1);
            end
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL reset_mid_refresh k=%0d: got=%b expected=%b", k, obs(), exp);
            end
            if (k == 1) bus.ref_req = 1'b0;
            if (k == 4) reset = 1'b1;
            if (k == 6) reset = 1'b0;
        end
        idle(6);
    endtask
`else
    task automatic test_refresh_disabled();
        logic [8:0] exp;
        int g;
        set_reqs(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            g   = (k == 0) ? 2 : 0;
            exp = pack(g, code_of(g, 1'b0), k < 3);
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL refresh_disabled k=%0d: got=%b expected=%b", k, obs(), exp);
            end
            if (k == 1) bus.cas_req = 1'b0;
        end
        idle(6);
    endtask
`endif

    // Random traffic checked against timing rules expressed as edge-number distances.
    task automatic test_random();
        int last_act;
        int last_cas;
        int ref_edge;
        int prev;
        int g;
        logic a, c, rw, p, r;
        logic bsy;
        logic [8:0] exp;
        last_act = -1000;
        last_cas = -1000;
        ref_edge = -1000;
        prev     = 0;
        a = 1'b0; c = 1'b0; rw = 1'b0; p = 1'b0; r = 1'b0;
        set_reqs(a, c, rw, p, r);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int t = 0; t < 400; t++) begin
            tick();
            g = 0;
            if (t >= ref_edge + TRFC + 1) begin
                if (REF_EN && r && prev != 4) g = 4;
                else if (p && prev != 3) g = 3;
                else if (c && (t - last_cas) >= TCCD && prev != 2) g = 2;
                else if (a && (t - last_act) >= TRRD && prev != 1) g = 1;
            end
            if (g == 1) last_act = t;
            if (g == 2) last_cas = t;
            if (g == 4) ref_edge = t;
            bsy = (t < ref_edge + TRFC) || ((t - last_act) < TRRD - 1) || ((t - last_cas) < TCCD - 1);
            exp = pack(g, code_of(g, rw), bsy);
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL random t=%0d: got=%b expected=%b", t, obs(), exp);
            end
            if (prev == 1) a = 1'b0;
            else if (!a && $urandom_range(0, 2) == 0) a = 1'b1;
            if (prev == 2) c = 1'b0;
            else if (!c && $urandom_range(0, 2) == 0) begin
                c  = 1'b1;
                rw = 1'($urandom_range(0, 1));
            end
            if (prev == 3) p = 1'b0;
            else if (!p && $urandom_range(0, 3) == 0) p = 1'b1;
            if (prev == 4) r = 1'b0;
            else if (!r && $urandom_range(0, 39) == 0) r = 1'b1;
            prev = g;
            set_reqs(a, c, rw, p, r);
        end
        idle(4);
    endtask

    initial begin
        set_reqs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_act_spacing();
        test_cas_priority();
        test_ccd_bypass();
`ifdef DDR_CMD_ARB_REFRESH_EN
        test_refresh();
        test_reset_mid_refresh();
`else
        test_refresh_disabled();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/ddr_cmd_arb.md
DDR_CMD_ARB -- requirements
Module: ddr_cmd_arb

Interface
REQ-001 Parameter TRRD, default 4, minimum clock_t cycles between consecutive ACT grants.
REQ-002 Parameter TCCD, default 4, minimum clock_t cycles between consecutive CAS grants.
REQ-003 Parameter TRFC, default 20, clock_t cycles the command bus stays blocked after a REF grant.
REQ-004 clock_t  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 act_req, pre_req, ref_req  input  1 each  level requests, held until granted.
REQ-007 cas_req  input  1  CAS request, held until granted.
REQ-008 cas_rw  input  1  CAS type, sampled with cas_req; 0 = read, 1 = write.
REQ-009 act_gnt, cas_gnt, pre_gnt, ref_gnt  output  1 each  single-cycle registered grant pulses.
REQ-010 cmd_valid  output  1  a command is issued this cycle.
REQ-011 cmd_code  output  3  000 NOP, 001 ACT, 010 RD, 011 WR, 100 PRE, 101 REF.
REQ-012 busy  output  1  high while in ARB_REF_WAIT or while any timer is nonzero.

Function
REQ-013 The FSM SHALL have exactly two states: ARB_RUN and ARB_REF_WAIT.
REQ-014 In ARB_RUN, eligible requests SHALL be granted by fixed priority REF > PRE > CAS > ACT, with at most one grant per cycle.
REQ-015 A request SHALL be eligible as follows: ACT when rrd_cnt == 0; CAS when ccd_cnt == 0; PRE and REF unconditionally.
REQ-016 Latency: a request that is eligible at rising edge N SHALL produce its gnt, cmd_valid and cmd_code in the cycle after edge N, all registered.
REQ-017 Requesters drop req the cycle after gnt; the block SHALL NOT re-grant a req that is still high in the grant cycle.
REQ-018 On an ACT grant, rrd_cnt SHALL load TRRD-1; on a CAS grant, ccd_cnt SHALL load TCCD-1; each counter decrements by 1 per cycle and saturates at 0.
REQ-019 The CAS grant SHALL drive cmd_code 010 when cas_rw = 0 and 011 when cas_rw = 1.
REQ-020 On a REF grant, the FSM SHALL enter ARB_REF_WAIT, load rfc_cnt with TRFC-1, and issue no grants until rfc_cnt == 0; it then returns to ARB_RUN.
REQ-021 rrd_cnt and ccd_cnt SHALL keep decrementing during ARB_REF_WAIT.
REQ-022 When no grant is issued, the block SHALL drive cmd_valid = 0 and cmd_code = 000.
REQ-023 Simultaneous requests: only the highest-priority eligible request is granted; the others stay pending with no state loss.
REQ-024 An ineligible higher-priority request SHALL NOT block a lower-priority eligible one (e.g. CAS blocked by ccd_cnt, ACT eligible: ACT is granted).
REQ-025 All counters SHALL be at least clog2(max(TRRD, TCCD, TRFC)) + 1 bits wide, with no wrap-around.

Reset
REQ-026 While reset = 1 at a clock_t edge, the block SHALL load: state ARB_RUN, all counters 0, all gnt outputs 0, cmd_valid 0, cmd_code 000, busy 0.
REQ-027 Reset asserted mid-ARB_REF_WAIT SHALL abort the wait; with ref_req low, the first grant is possible in the second cycle after reset deasserts.

Configuration
REQ-028 Macro DDR_CMD_ARB_REFRESH_EN defined: the REF path, ARB_REF_WAIT and rfc_cnt SHALL be implemented as described above.
REQ-029 Macro DDR_CMD_ARB_REFRESH_EN undefined: ref_req SHALL be ignored, ref_gnt tied to 0, code 101 never issued, the FSM stays permanently in ARB_RUN, and rfc_cnt is not built.

Verification
REQ-030 act_req held high across two transactions with TRRD=4 -> act_gnt pulses 4 cycles apart, cmd_code 001 each time.
REQ-031 cas_req with cas_rw=1 and act_req asserted in the same cycle, timers at 0 -> cas_gnt first (cmd_code 011); act_gnt in the next cycle.
REQ-032 ref_req and pre_req together, TRFC=20 -> ref_gnt (101), no grant for 20 cycles, then pre_gnt (100).
REQ-033 CAS granted, second cas_req plus act_req 1 cycle later, TCCD=4 -> act_gnt next cycle, cas_gnt 4 cycles after the first CAS.
REQ-034 reset pulsed 5 cycles into ARB_REF_WAIT -> all outputs 0 during reset; a pending act_req is granted in the second cycle after release.
REQ-035 DDR_CMD_ARB_REFRESH_EN undefined, ref_req held high with cas_req -> ref_gnt stays 0 and cas_gnt is issued normally.
